dm9000_reg_writer: RTL

//   Host-bus write engine for the DM9000A Ethernet controller on the 50 MHz domain.
//   - Takes one (register index, 16-bit data) request.
//   - Performs the two-step DM9000A write: an index cycle with CMD=0, then a data cycle with CMD=1.
//   - Counterpart of the DM9000A register-read sequencer; used for PHY power-up, NCR/RCR/IMR setup and TX.
//   - Drives the chip pins through an external tristate (eth_data = oe ? o : 'z).

---
 rtl/dm9000_reg_writer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/dm9000_reg_writer.sv
`timescale 1ns/1ps
// dm9000_reg_writer
//   Two-step DM9000A host-bus register write: an index cycle (CMD=0) carrying the
//   register number, a bus-released gap, then a data cycle (CMD=1) carrying the value.
//   All pin outputs are registers, so the strobes are glitch-free; async reset
//   releases the bus immediately.
//   Optional macro DM9000_WR_FIFO_EN adds a 4-entry request FIFO in front of the FSM.
module dm9000_reg_writer #(
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 2,
    parameter int T_HOLD   = 1,
    parameter int T_GAP    = 2
) (
    input  logic        clk50M,
    input  logic        rst_key,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_data,
    output logic        done,
    output logic        busy,
    output logic        eth_cs,
    output logic        eth_cmd,
    output logic        eth_iow,
    output logic        eth_ior,
    output logic [15:0] eth_data_o,
    output logic        eth_data_oe
);

    if (T_SETUP < 1 || T_STROBE < 1 || T_HOLD < 1 || T_GAP < 1) begin : g_bad_param
        $error("dm9000_reg_writer: every T_* parameter must be >= 1");
    end

    localparam int MAX_A = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
    localparam int MAX_B = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = (MAX_T < 1) ? 1 : $clog2(MAX_T + 1);

    localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_GAP    = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE, IDX_SETUP, IDX_STROBE, IDX_HOLD, GAP, DAT_SETUP, DAT_STROBE, DAT_HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             fsm_busy;
    logic [15:0]      data_q;

    // Request source feeding the FSM: either the port directly or the FIFO head
    logic             start;
    logic [7:0]       start_addr;
    logic [15:0]      start_data;

    // This block never reads the chip
    assign eth_ior = 1'b1;

`ifdef DM9000_WR_FIFO_EN
    logic [7:0]  fifo_addr [4];
    logic [15:0] fifo_data [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  fifo_cnt;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;

    assign fifo_full  = (fifo_cnt == 3'd4);
    assign fifo_empty = (fifo_cnt == 3'd0);
    // A full FIFO refuses pushes even when a pop happens the same cycle
    assign push       = req_valid & ~fifo_full;
    assign pop        = (state == IDLE) & ~fifo_empty;
    assign req_ready  = ~fifo_full;
    assign busy       = fsm_busy | ~fifo_empty;
    assign start      = pop;
    assign start_addr = fifo_addr[rd_ptr];
    assign start_data = fifo_data[rd_ptr];

    // FIFO pointers and occupancy; reset empties the queue
    always_ff @(posedge clk50M or negedge rst_key) begin
        if (!rst_key) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage, written on every accepted push
    always_ff @(posedge clk50M) begin
        if (push) begin
            fifo_addr[wr_ptr] <= req_addr;
            fifo_data[wr_ptr] <= req_data;
        end
    end
`else
    assign req_ready  = ~fsm_busy;
    assign busy       = fsm_busy;
    assign start      = req_valid & ~fsm_busy;
    assign start_addr = req_addr;
    assign start_data = req_data;
`endif

    // Hold the data word until the data cycle; the index goes straight to the bus
    always_ff @(posedge clk50M) begin
        if (start) data_q <= start_data;
    end

    // Bus sequencer: one down-counter times every phase, outputs set on state entry
    always_ff @(posedge clk50M or negedge rst_key) begin
        if (!rst_key) begin
            state       <= IDLE;
            cnt         <= '0;
            fsm_busy    <= 1'b0;
            done        <= 1'b0;
            eth_cs      <= 1'b1;
            eth_cmd     <= 1'b1;
            eth_iow     <= 1'b1;
            eth_data_o  <= '0;
            eth_data_oe <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && cnt != '0) begin
                cnt <= cnt - CNT_ONE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state       <= IDX_SETUP;
                            cnt         <= LD_SETUP;
                            fsm_busy    <= 1'b1;
                            eth_cs      <= 1'b0;
                            eth_cmd     <= 1'b0;
                            eth_data_oe <= 1'b1;
                            eth_data_o  <= {8'h00, start_addr};
                        end
                    end
                    IDX_SETUP: begin
                        state   <= IDX_STROBE;
                        cnt     <= LD_STROBE;
                        eth_iow <= 1'b0;
                    end
                    IDX_STROBE: begin
                        state   <= IDX_HOLD;
                        cnt     <= LD_HOLD;
                        eth_iow <= 1'b1;
                    end
                    IDX_HOLD: begin
                        state       <= GAP;
                        cnt         <= LD_GAP;
                        eth_cs      <= 1'b1;
                        eth_cmd     <= 1'b1;
                        eth_data_oe <= 1'b0;
                        eth_data_o  <= '0;
                    end
                    GAP: begin
                        state       <= DAT_SETUP;
                        cnt         <= LD_SETUP;
                        eth_cs      <= 1'b0;
                        eth_cmd     <= 1'b1;
                        eth_data_oe <= 1'b1;
                        eth_data_o  <= data_q;
                    end
                    DAT_SETUP: begin
                        state   <= DAT_STROBE;
                        cnt     <= LD_STROBE;
                        eth_iow <= 1'b0;
                    end
                    DAT_STROBE: begin
                        state   <= DAT_HOLD;
                        cnt     <= LD_HOLD;
                        eth_iow <= 1'b1;
                    end
                    DAT_HOLD: begin
                        state       <= IDLE;
                        fsm_busy    <= 1'b0;
                        done        <= 1'b1;
                        eth_cs      <= 1'b1;
                        eth_cmd     <= 1'b1;
                        eth_data_oe <= 1'b0;
                        eth_data_o  <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
